rterm_cal_ctrl: RTL



---
 rtl/rterm_cal_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/rterm_cal_ctrl.sv
// ---------------------------------------------------------------------------
// rterm_cal_ctrl
//
// Sequential calibration controller for the EG1d80V IO termination-trim
// cells. For the selected channel it sweeps the trim code upward from 0. At
// each code it waits a settle time and then majority-filters the
// synchronised comparator output. The first code whose filtered result is 1
// is latched as that channel's stored code.
//
// Ports
//   CLK_I         clock
//   RST_I         asynchronous active-high reset
//   START_I       one-cycle request to calibrate channel CH_SEL_I
//   ABORT_I       abort the running calibration
//   CH_SEL_I      channel to calibrate (sampled with START_I)
//   RESULT_I      raw asynchronous comparator outputs, one per channel
//   MODE_O        one-hot comparator enable for the active channel
//   TRIM_O        per-channel trim drive (thermometer or zero-extended binary)
//   CODE_O        per-channel stored binary code
//   CODE_VALID_O  channel calibrated successfully since reset
//   BUSY_O        calibration in progress
//   DONE_O        one-cycle completion pulse
//   ERR_O         00 ok, 01 low rail, 10 high rail, 11 abort/invalid channel
// ---------------------------------------------------------------------------
module rterm_cal_ctrl #(
  parameter int              CODE_W     = 4,
  parameter int              N_CH       = 2,
  parameter logic [N_CH-1:0] CH_THERMO  = 2'b01,
  parameter int              SETTLE_CYC = 16,
  parameter int              N_SAMPLE   = 4,
  parameter int              RST_CODE   = 0,
  localparam int             MAXC       = 2**CODE_W - 1,
  localparam int             THERMO_W   = MAXC,
  localparam int             CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       CLK_I,
  input  logic                       RST_I,
  input  logic                       START_I,
  input  logic                       ABORT_I,
  input  logic [CH_W-1:0]            CH_SEL_I,
  input  logic [N_CH-1:0]            RESULT_I,
  output logic [N_CH-1:0]            MODE_O,
  output logic [N_CH*THERMO_W-1:0]   TRIM_O,
  output logic [N_CH*CODE_W-1:0]     CODE_O,
  output logic [N_CH-1:0]            CODE_VALID_O,
  output logic                       BUSY_O,
  output logic                       DONE_O,
  output logic [1:0]                 ERR_O
);

  localparam int                  ONES_W      = $clog2(N_SAMPLE + 1);
  localparam int                  T_MAX       = (SETTLE_CYC > N_SAMPLE) ? SETTLE_CYC : N_SAMPLE;
  localparam int                  TMR_W       = $clog2(T_MAX + 1);
  localparam logic [TMR_W-1:0]    SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0]    SAMPLE_LAST = TMR_W'(N_SAMPLE - 1);
  localparam logic [ONES_W-1:0]   HALF        = ONES_W'(N_SAMPLE / 2);
  localparam logic [CODE_W-1:0]   MAXC_V      = '1;
  localparam logic [CODE_W-1:0]   RST_CODE_V  = CODE_W'(RST_CODE);
  localparam logic [CH_W:0]       N_CH_V      = (CH_W + 1)'(N_CH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DECIDE,
    ST_FIN
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          err_nxt;
  logic [N_CH-1:0]     res_sync_p0;
  logic [N_CH-1:0]     res_sync_p1;
  logic [CH_W-1:0]     ch_q;
  logic [CODE_W-1:0]   k_q;
  logic [TMR_W-1:0]    tmr_q;
  logic [ONES_W-1:0]   ones_q;
  logic [CODE_W-1:0]   code_q [N_CH];
  logic [N_CH-1:0]     code_valid_q;
  logic [1:0]          err_q;
  logic                ch_valid;
  logic                hit;
  logic                at_max;
  logic                sweeping;

  function automatic logic [THERMO_W-1:0] thermo_enc(input logic [CODE_W-1:0] k);
    logic [THERMO_W-1:0] t;
    t = '0;
    for (int i = 0; i < THERMO_W; i++) begin
      t[i] = (i < int'(k));
    end
    return t;
  endfunction

  function automatic logic [THERMO_W-1:0] binary_enc(input logic [CODE_W-1:0] k);
    return THERMO_W'(k);
  endfunction

  assign ch_valid = ({1'b0, CH_SEL_I} < N_CH_V);
  assign hit      = (ones_q > HALF);
  assign at_max   = (k_q == MAXC_V);
  assign sweeping = (state == ST_SETUP) || (state == ST_SETTLE) ||
                    (state == ST_SAMPLE) || (state == ST_DECIDE);

  // ---- state register ----
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 2'b11;
    case (state)
      ST_IDLE: begin
        if (START_I) begin
          state_nxt = ch_valid ? ST_SETUP : ST_FIN;
        end
      end
      ST_SETUP:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (tmr_q == SETTLE_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (tmr_q == SAMPLE_LAST) state_nxt = ST_DECIDE;
      ST_DECIDE: begin
        if (hit) begin
          state_nxt = ST_FIN;
          err_nxt   = (k_q == '0) ? 2'b01 : 2'b00;
        end else if (at_max) begin
          state_nxt = ST_FIN;
          err_nxt   = 2'b10;
        end else begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Abort wins over anything DECIDE concluded in the same cycle.
    if (ABORT_I && (state != ST_IDLE) && (state != ST_FIN)) begin
      state_nxt = ST_FIN;
      err_nxt   = 2'b11;
    end
  end

  // ---- synchroniser p0 -> p1, sweep datapath ----
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      res_sync_p0  <= '0;
      res_sync_p1  <= '0;
      ch_q         <= '0;
      k_q          <= '0;
      tmr_q        <= '0;
      ones_q       <= '0;
      code_valid_q <= '0;
      err_q        <= 2'b00;
      for (int c = 0; c < N_CH; c++) begin
        code_q[c] <= RST_CODE_V;
      end
    end else begin
      res_sync_p0 <= RESULT_I;
      res_sync_p1 <= res_sync_p0;
      // Timer restarts on every state change, so each state counts from 0.
      tmr_q <= (state_nxt != state) ? '0 : tmr_q + 1'b1;
      case (state)
        ST_IDLE: begin
          if (START_I && ch_valid) begin
            ch_q <= CH_SEL_I;
            k_q  <= '0;
          end
        end
        ST_SETUP: ones_q <= '0;
        ST_SAMPLE: begin
          if (res_sync_p1[ch_q]) begin
            ones_q <= ones_q + 1'b1;
          end
        end
        ST_DECIDE: begin
          if (!ABORT_I) begin
            if (hit || at_max) begin
              code_q[ch_q] <= k_q;
              if (hit && (k_q != '0)) begin
                code_valid_q[ch_q] <= 1'b1;
              end
            end else begin
              k_q    <= k_q + 1'b1;
              ones_q <= '0;
            end
          end
        end
        default: ;
      endcase
      if (state_nxt == ST_FIN) begin
        err_q <= err_nxt;
      end
    end
  end

  // ---- output encode ----
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic              active;
    logic [CODE_W-1:0] cur_code;
    assign active    = sweeping && (ch_q == CH_W'(g));
    assign cur_code  = active ? k_q : code_q[g];
    assign MODE_O[g] = active;
    assign TRIM_O[g*THERMO_W +: THERMO_W] = CH_THERMO[g] ? thermo_enc(cur_code)
                                                         : binary_enc(cur_code);
    assign CODE_O[g*CODE_W +: CODE_W] = code_q[g];
  end

  assign CODE_VALID_O = code_valid_q;
  assign BUSY_O       = sweeping;
  assign DONE_O       = (state == ST_FIN);
  assign ERR_O        = err_q;

endmodule
